// File: rtl/ball_motion.sv
// ball_motion: pong ball engine. Advances the ball once per frame tick,
// bounces it off the top/bottom walls and the paddles, detects misses,
// keeps both score counters and sequences serve / score-hold / recentre.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   tick                  one-cycle frame strobe; motion only happens on it
//   serve                 level, leaves IDLE on a tick
//   wall_width            top/bottom wall thickness
//   ball_width            side of the square ball
//   paddle_width          paddle thickness
//   paddle_length         paddle height
//   left_paddle_y         upper edge of the left paddle
//   right_paddle_y        upper edge of the right paddle
//   ball_x, ball_y        upper-left corner of the ball
//   ball_direction        1 = moving left, 0 = moving right
//   score_left_pulse      one-cycle pulse after the left player scores
//   score_right_pulse     one-cycle pulse after the right player scores
//   score_left/right      saturating (15) score counters
//   playing               high while in PLAY
//
// state  | meaning
// IDLE   | ball shown centred, waiting for serve on a tick
// PLAY   | ball moves on every tick
// SCORED | ball frozen, counting HOLD_TICKS ticks before recentring
module ball_motion #(
  parameter int SCREEN_W         = 640,
  parameter int SCREEN_H         = 480,
  parameter int DX_INIT          = 2,
  parameter int DX_MAX           = 6,
  parameter int DY               = 1,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int HOLD_TICKS       = 60,
  parameter int AUTO_SERVE       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       serve,
  input  logic [5:0] wall_width,
  input  logic [5:0] ball_width,
  input  logic [5:0] paddle_width,
  input  logic [8:0] paddle_length,
  input  logic [8:0] left_paddle_y,
  input  logic [8:0] right_paddle_y,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic       ball_direction,
  output logic       score_left_pulse,
  output logic       score_right_pulse,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       playing
);

  localparam int DXW = $clog2(DX_MAX + 1);
  localparam int HCW = $clog2(HITS_PER_SPEEDUP + 1);
  localparam int HDW = $clog2(HOLD_TICKS + 1);
  localparam logic [DXW-1:0] DX_INIT_V = DXW'(DX_INIT);
  localparam logic [DXW-1:0] DX_MAX_V  = DXW'(DX_MAX);
  localparam logic [HCW-1:0] HITS_LAST = HCW'(HITS_PER_SPEEDUP - 1);
  localparam logic [HDW-1:0] HOLD_LAST = HDW'(HOLD_TICKS - 1);
  localparam logic [10:0]    W11       = 11'(SCREEN_W);
  localparam logic [10:0]    H11       = 11'(SCREEN_H);
  localparam logic [10:0]    DY11      = 11'(DY);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SCORED} state_t;

  state_t         state_q, state_d;
  logic [9:0]     x_q;
  logic [8:0]     y_q;
  logic           dir_q, vdir_q, scorer_right_q;
  logic [DXW-1:0] dx_q;
  logic [HCW-1:0] hit_q;
  logic [HDW-1:0] hold_q;
  logic [3:0]     score_l_q, score_r_q;
  logic           pulse_l_q, pulse_r_q;

  // Everything widened to 11 bits so sums and differences never wrap.
  logic [10:0] x_w, y_w, bw_w, pw_w, ww_w, pl_w, lpy_w, rpy_w, dx_w;
  logic [10:0] face_w, right_edge_w;
  logic [9:0]  centre_x;
  logic [8:0]  centre_y;
  logic        left_ovl, right_ovl, left_hit, right_hit;
  logic        left_scores, right_scores, hold_done;
  logic [10:0] x_mv, y_mv;
  logic        dir_mv, vdir_mv;

  assign x_w          = {1'b0, x_q};
  assign y_w          = {2'b0, y_q};
  assign bw_w         = {5'b0, ball_width};
  assign pw_w         = {5'b0, paddle_width};
  assign ww_w         = {5'b0, wall_width};
  assign pl_w         = {2'b0, paddle_length};
  assign lpy_w        = {2'b0, left_paddle_y};
  assign rpy_w        = {2'b0, right_paddle_y};
  assign dx_w         = 11'(dx_q);
  assign face_w       = W11 - pw_w;
  assign right_edge_w = x_w + bw_w;
  assign centre_x     = 10'((W11 - bw_w) >> 1);
  assign centre_y     = 9'((H11 - bw_w) >> 1);
  assign hold_done    = (hold_q == HOLD_LAST);

  // Hit zones only accept a ball still in front of the face, so a ball that
  // already slipped past a paddle can only go on to score.
  always_comb begin
    left_ovl     = (y_w + bw_w > lpy_w) && (y_w < lpy_w + pl_w);
    right_ovl    = (y_w + bw_w > rpy_w) && (y_w < rpy_w + pl_w);
    left_hit     = dir_q && (x_w >= pw_w) && (x_w < pw_w + dx_w) && left_ovl;
    right_scores = dir_q && !left_hit && (x_w < dx_w);
    right_hit    = !dir_q && (right_edge_w <= face_w) &&
                   (right_edge_w + dx_w > face_w) && right_ovl;
    left_scores  = !dir_q && !right_hit && (right_edge_w + dx_w > W11);
  end

  always_comb begin
    x_mv   = x_w;
    dir_mv = dir_q;
    if (left_hit) begin
      x_mv   = pw_w;
      dir_mv = 1'b0;
    end else if (right_hit) begin
      x_mv   = face_w - bw_w;
      dir_mv = 1'b1;
    end else if (dir_q && !right_scores) begin
      x_mv = x_w - dx_w;
    end else if (!dir_q && !left_scores) begin
      x_mv = x_w + dx_w;
    end
  end

  always_comb begin
    y_mv    = y_w;
    vdir_mv = vdir_q;
    if (vdir_q) begin
      if (y_w + bw_w + DY11 > H11 - ww_w) begin
        y_mv    = H11 - ww_w - bw_w;
        vdir_mv = 1'b0;
      end else begin
        y_mv = y_w + DY11;
      end
    end else if (y_w < ww_w + DY11) begin
      y_mv    = ww_w;
      vdir_mv = 1'b1;
    end else begin
      y_mv = y_w - DY11;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tick && (serve || AUTO_SERVE != 0)) state_d = S_PLAY;
      S_PLAY:   if (tick && (left_scores || right_scores)) state_d = S_SCORED;
      S_SCORED: if (tick && hold_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q            <= '0;
      y_q            <= '0;
      dir_q          <= 1'b1;
      vdir_q         <= 1'b1;
      scorer_right_q <= 1'b1;
      dx_q           <= DX_INIT_V;
      hit_q          <= '0;
      hold_q         <= '0;
      score_l_q      <= '0;
      score_r_q      <= '0;
      pulse_l_q      <= 1'b0;
      pulse_r_q      <= 1'b0;
    end else begin
      pulse_l_q <= 1'b0;
      pulse_r_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Track the centre so PLAY starts from it with no extra step.
          x_q <= centre_x;
          y_q <= centre_y;
        end
        S_PLAY: if (tick) begin
          if (left_scores || right_scores) begin
            pulse_l_q      <= left_scores;
            pulse_r_q      <= right_scores;
            scorer_right_q <= right_scores;
            hold_q         <= '0;
            if (left_scores && score_l_q != 4'hf)  score_l_q <= score_l_q + 4'd1;
            if (right_scores && score_r_q != 4'hf) score_r_q <= score_r_q + 4'd1;
          end else begin
            x_q    <= 10'(x_mv);
            y_q    <= 9'(y_mv);
            dir_q  <= dir_mv;
            vdir_q <= vdir_mv;
            if (left_hit || right_hit) begin
              if (hit_q == HITS_LAST) begin
                hit_q <= '0;
                if (dx_q < DX_MAX_V) dx_q <= dx_q + 1'b1;
              end else begin
                hit_q <= hit_q + 1'b1;
              end
            end
          end
        end
        S_SCORED: if (tick) begin
          if (hold_done) begin
            x_q    <= centre_x;
            y_q    <= centre_y;
            dx_q   <= DX_INIT_V;
            hit_q  <= '0;
            vdir_q <= 1'b1;
            dir_q  <= scorer_right_q;
            hold_q <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // In IDLE the position is taken straight from the centre so that reset,
  // whose value depends on ball_width, centres the ball immediately.
  always_comb begin
    ball_x            = (state_q == S_IDLE) ? centre_x : x_q;
    ball_y            = (state_q == S_IDLE) ? centre_y : y_q;
    ball_direction    = dir_q;
    score_left_pulse  = pulse_l_q;
    score_right_pulse = pulse_r_q;
    score_left        = score_l_q;
    score_right       = score_r_q;
    playing           = (state_q == S_PLAY);
  end

endmodule
